// File: rtl/goto_rep_gen.sv
// Responder for "a |-> b[->num]": per accepted trigger, emits num b pulses each preceded by gap idle cycles.
// Optional completed-sequence counter on seq_cnt enabled by defining GOTO_REP_GEN_STATS_EN.
module goto_rep_gen #(
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic [CNT_W-1:0] num,
    input  logic [GAP_W-1:0] gap,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [15:0]      seq_cnt
);
    localparam int unsigned SEQ_W = 16;

    // PULSE is the cycle in which b is high; GAP counts down the b-low cycles before it
    typedef enum logic [1:0] {IDLE, GAP, PULSE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             done_d;

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        pcnt_d  = pcnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (a) begin
                    num_d  = num;
                    gap_d  = gap;
                    gcnt_d = gap;
                    pcnt_d = '0;
                    if (num == '0) begin
                        done_d = 1'b1;
                    end else if (gap == '0) begin
                        state_d = PULSE;
                        pcnt_d  = CNT_W'(1);
                        done_d  = (num == CNT_W'(1));
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gcnt_q == GAP_W'(1)) begin
                    state_d = PULSE;
                    pcnt_d  = pcnt_q + CNT_W'(1);
                    done_d  = (pcnt_d == num_q);
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            PULSE: begin
                // a is not looked at here, so a trigger during the final pulse is dropped
                if (pcnt_q == num_q) begin
                    state_d = IDLE;
                end else if (gap_q == '0) begin
                    pcnt_d = pcnt_q + CNT_W'(1);
                    done_d = (pcnt_d == num_q);
                end else begin
                    state_d = GAP;
                    gcnt_d  = gap_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            pcnt_q  <= '0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            pcnt_q  <= pcnt_d;
            b       <= (state_d == PULSE);
            busy    <= (state_d != IDLE);
            done    <= done_d;
        end
    end

`ifdef GOTO_REP_GEN_STATS_EN
    logic [SEQ_W-1:0] seq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q <= '0;
        end else if (done_d) begin
            seq_q <= seq_q + SEQ_W'(1);
        end
    end

    assign seq_cnt = seq_q;
`else
    assign seq_cnt = SEQ_W'(0);
`endif

endmodule

// File: tb/tb_goto_rep_gen.sv
// Self-checking bench for goto_rep_gen: vector table plus hand-written reset/priority/wrap sequences.
module tb_goto_rep_gen;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a;
    logic [CNT_W-1:0] num;
    logic [GAP_W-1:0] gap;
    logic             b;
    logic             busy;
    logic             done;
    logic [15:0]      seq_cnt;

    goto_rep_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .a(a), .num(num), .gap(gap),
        .b(b), .busy(busy), .done(done), .seq_cnt(seq_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        b;
        logic        busy;
        logic        done;
        logic [15:0] seq;
    } exp_t;

    typedef struct {
        int num;
        int gap;
        int hold;
        int tail;
        int exp_pulses;
    } vec_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   b_seen      = 0;

    // Analytic expectation: pulse i of a sequence accepted at edge k lands at edge k+gap+i*(gap+1)
    int          t       = 0;
    bit          started = 1'b0;
    int          mk, mn, mg, mend, mfree;
    logic [15:0] mseq    = 16'h0;

    task automatic cycle(input logic r, input logic ta, input int tn, input int tg, input string name);
        exp_t e;
        exp_t got;
        int   j;
        @(negedge clk);
        rst = r;
        a   = ta;
        num = CNT_W'(tn);
        gap = GAP_W'(tg);
        @(posedge clk);
        t++;
        e = '0;
        if (r) begin
            started = 1'b0;
            mseq    = 16'h0;
        end else begin
            if (ta && (!started || t >= mfree)) begin
                started = 1'b1;
                mk      = t;
                mn      = tn;
                mg      = tg;
                mend    = (tn == 0) ? t : t + tg + (tn - 1) * (tg + 1);
                mfree   = (tn == 0) ? mend + 1 : mend + 2;
            end
            if (started && t <= mend) begin
                j      = t - mk;
                e.done = (t == mend);
                e.busy = (mn > 0);
                e.b    = (mn > 0) && (j >= mg) && ((j - mg) % (mg + 1) == 0);
            end
`ifdef GOTO_REP_GEN_STATS_EN
            if (e.done) mseq = mseq + 16'd1;
`endif
        end
        e.seq = mseq;
        sb.push_back(e);
        #1;
        e   = sb.pop_front();
        got = {b, busy, done, seq_cnt};
        vectors++;
        if (b) b_seen++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s edge=%0d: got b=%b busy=%b done=%b seq=%0d, want b=%b busy=%b done=%b seq=%0d",
                     name, t, got.b, got.busy, got.done, got.seq, e.b, e.busy, e.done, e.seq);
        end
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{num: 0,  gap: 0,  hold: 1,  tail: 3,   exp_pulses: 0};
        tbl[1] = '{num: 3,  gap: 2,  hold: 1,  tail: 12,  exp_pulses: 3};
        tbl[2] = '{num: 4,  gap: 0,  hold: 1,  tail: 6,   exp_pulses: 4};
        tbl[3] = '{num: 2,  gap: 3,  hold: 12, tail: 10,  exp_pulses: 4};
        tbl[4] = '{num: 1,  gap: 0,  hold: 1,  tail: 3,   exp_pulses: 1};
        tbl[5] = '{num: 15, gap: 15, hold: 1,  tail: 245, exp_pulses: 15};
        tbl[6] = '{num: 15, gap: 0,  hold: 1,  tail: 18,  exp_pulses: 15};
        tbl[7] = '{num: 0,  gap: 5,  hold: 3,  tail: 2,   exp_pulses: 0};
        tbl[8] = '{num: 1,  gap: 4,  hold: 1,  tail: 8,   exp_pulses: 1};

        rst = 1'b1;
        a   = 1'b0;
        num = '0;
        gap = '0;
        cycle(1'b1, 1'b0, 0, 0, "reset");
        cycle(1'b1, 1'b1, 3, 1, "reset");
        cycle(1'b0, 1'b0, 0, 0, "idle");

        // Inputs are randomised while a is low to show latched values are used
        for (int v = 0; v < 9; v++) begin
            b_seen = 0;
            for (int h = 0; h < tbl[v].hold; h++)
                cycle(1'b0, 1'b1, tbl[v].num, tbl[v].gap, "tbl");
            for (int c = 0; c < tbl[v].tail; c++)
                cycle(1'b0, 1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "tbl");
            vectors++;
            if (b_seen != tbl[v].exp_pulses) begin
                miscompares++;
                $display("FAIL pulse_count row=%0d: got %0d pulses, want %0d", v, b_seen, tbl[v].exp_pulses);
            end
        end

        // Reset after the second pulse aborts the sequence
        cycle(1'b0, 1'b1, 5, 1, "abort");
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 5, 1, "abort");
        cycle(1'b1, 1'b0, 5, 1, "abort");
        for (int c = 0; c < 12; c++) cycle(1'b0, 1'b0, 5, 1, "abort");

        // Reset and trigger on the same edge: trigger dropped
        cycle(1'b1, 1'b1, 2, 0, "rst_prio");
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0, 2, 0, "rst_prio");

`ifdef GOTO_REP_GEN_STATS_EN
        cycle(1'b1, 1'b0, 0, 0, "wrap");
        for (int c = 0; c < 65536; c++) cycle(1'b0, 1'b1, 0, 0, "wrap");
        cycle(1'b0, 1'b0, 0, 0, "wrap");
        vectors++;
        if (seq_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL stats_wrap: got seq_cnt=%0d, want 0", seq_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/goto_rep_gen.md
GOTO_REP_GEN -- requirements
Module: goto_rep_gen

Interface
REQ-001 The block SHALL have a parameter CNT_W, default 4, giving the width of the pulse-count input num.
REQ-002 The block SHALL have a parameter GAP_W, default 4, giving the width of the gap input.
REQ-003 Port clk: input, 1 bit, the single clock; all state SHALL update on the posedge.
REQ-004 Port rst: input, 1 bit, synchronous active-high reset.
REQ-005 Port a: input, 1 bit, trigger, sampled at posedge clk.
REQ-006 Port num: input, CNT_W bits, number of b pulses to emit per trigger; 0 is legal.
REQ-007 Port gap: input, GAP_W bits, number of b-low cycles before each b pulse.
REQ-008 Port b: output, 1 bit, registered response pulse.
REQ-009 Port busy: output, 1 bit, high while a sequence is in progress.
REQ-010 Port done: output, 1 bit, one-cycle sequence-complete strobe.
REQ-011 Port seq_cnt: output, 16 bits, count of completed sequences (see Configuration).

Function
REQ-012 The block SHALL implement the responder for property "a |-> b[->num]": after an accepted trigger, exactly num non-consecutive-or-consecutive b pulses, then completion.
REQ-013 The FSM SHALL have states IDLE, GAP and PULSE; in IDLE, b=0 and busy=0.
REQ-014 In IDLE, a=1 at edge k SHALL be accepted; num and gap are latched at that edge, and later input changes SHALL be ignored until the next acceptance.
REQ-015 If the latched num=0: the FSM SHALL stay in IDLE, b SHALL stay 0, and done=1 SHALL be asserted for exactly the one cycle following edge k (empty match).
REQ-016 If the latched num>0: busy=1 SHALL be asserted from edge k; the FSM SHALL enter GAP with its gap counter set to the latched gap.
REQ-017 In GAP, b=0; after the latched gap cycles have elapsed, the FSM SHALL enter PULSE; gap=0 SHALL skip GAP entirely.
REQ-018 Timing: the first b SHALL be high in cycle k+1+gap; each b pulse SHALL be one cycle wide; exactly gap b-low cycles SHALL separate consecutive pulses.
REQ-019 With gap=0, the num pulses SHALL be back-to-back, giving b high for num consecutive cycles.
REQ-020 A pulse counter SHALL track emitted pulses; on the num-th pulse, done=1 SHALL be asserted in the same cycle as that b, and the FSM SHALL return to IDLE at the next edge with busy=0.
REQ-021 a=1 while not in IDLE (including the final-pulse cycle) SHALL be ignored; triggers SHALL NOT be queued.
REQ-022 After a num=0 completion, a=1 in the done cycle SHALL be accepted as a new trigger.
REQ-023 num = 2^CNT_W-1 and gap = 2^GAP_W-1 SHALL operate without counter overflow.

Reset
REQ-024 When rst=1 at a posedge, the block SHALL go to IDLE, clear all counters, and drive b=0, busy=0, done=0, seq_cnt=0 from that edge.
REQ-025 Reset mid-sequence SHALL abort the sequence: no further b pulses and no done for the aborted trigger.
REQ-026 When rst=1 and a=1 are sampled at the same edge, rst SHALL take priority and the trigger SHALL be dropped.

Configuration
REQ-027 With macro GOTO_REP_GEN_STATS_EN defined, seq_cnt SHALL increment by 1 on every done, including num=0 completions, and SHALL wrap from 16'hFFFF to 0.
REQ-028 Without GOTO_REP_GEN_STATS_EN, seq_cnt SHALL be tied to 0, no counter logic SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-029 Empty match: num=0, a=1 for one cycle at 4 ns (posedge 5 ns) -> done=1 for the cycle after 5 ns; b stays 0; busy stays 0.
REQ-030 Basic goto: num=3, gap=2, trigger at edge k -> b high in cycles k+3, k+6 and k+9; done=1 with the third b; busy=0 from k+10.
REQ-031 Back-to-back: num=4, gap=0 -> b high in cycles k+1 through k+4; done=1 in k+4.
REQ-032 Retrigger ignore: num=2, gap=3 with a held high for 12 cycles -> exactly one sequence of two pulses, then a new acceptance at the first IDLE edge.
REQ-033 Reset abort: num=5, gap=1, rst=1 after the second b -> b, busy and done stay 0 thereafter; with the macro defined, seq_cnt=0.
REQ-034 Stats wrap (macro defined): 65536 num=0 triggers -> seq_cnt returns to 0; macro undefined -> seq_cnt is constant 0.
